// File: rtl/dpram_sclk_be.sv
// dpram_sclk_be: 1W/1R single-clock RAM, byte enables, 1/2-cycle reads,
// bypass, zero-fill after reset. Lane parity: define DPRAM_SCLK_PARITY_EN.
module dpram_sclk_be #(
  parameter int ADDR_WIDTH     = 9,
  parameter int DATA_WIDTH     = 16,
  parameter int BYTE_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int ENABLE_BYPASS  = 1,
  parameter int CLEAR_ON_RESET = 1,
  parameter int STATE_KEEP     = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ADDR_WIDTH-1:0]                raddr,
  input  logic                                 re,
  input  logic [ADDR_WIDTH-1:0]                waddr,
  input  logic                                 we,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]     wbe,
  input  logic [DATA_WIDTH-1:0]                din,
  output logic [DATA_WIDTH-1:0]                dout,
  output logic                                 dout_vld,
  output logic                                 init_done,
  output logic                                 par_err
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_bw
    $fatal(1, "DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
    $fatal(1, "READ_LATENCY must be 1 or 2");
  end

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  rd_acc;
  logic                  wr_acc;
  logic                  clr_wr;
  logic                  hit;
  logic                  rd_perr;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  s1_vld;
  logic                  s1_perr;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  o_vld;
  logic                  o_perr;
  logic [DATA_WIDTH-1:0] o_data;

  // Requests are only honoured once the clear sweep has finished
  assign rd_acc = re & init_done & ~rst;
  assign wr_acc = we & init_done & ~rst & (|wbe);
  assign clr_wr = (state == CLEAR) & ~rst;
  assign hit    = (ENABLE_BYPASS != 0) & rd_acc & wr_acc
                & (raddr == waddr);

  // Post-write word: enabled lanes from din, others from storage
  always_comb begin
    wr_word = mem[waddr];
    for (int i = 0; i < NB; i++) begin
      if (wbe[i]) begin
        wr_word[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign rd_word = hit ? wr_word : mem[raddr];

  // Control FSM: zero-fill sweep after reset, then ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clr_addr  <= '0;
      init_done <= 1'b0;
    end else begin
      init_done <= (state == READY);
      unique case (state)
        CLEAR: begin
          clr_addr <= clr_addr + ADDR_WIDTH'(1);
          if (&clr_addr) state <= READY;
        end
        READY: state <= READY;
        default: state <= READY;
      endcase
    end
  end

  // Storage: clear sweep has priority, then merged user write
  always_ff @(posedge clk) begin
    if (clr_wr) begin
      mem[clr_addr] <= '0;
    end else if (wr_acc) begin
      mem[waddr] <= wr_word;
    end
  end

`ifdef DPRAM_SCLK_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];

  function automatic logic [NB-1:0] lane_par(
    input logic [DATA_WIDTH-1:0] w
  );
    logic [NB-1:0] p;
    for (int i = 0; i < NB; i++) begin
      p[i] = ^w[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return p;
  endfunction

  // Parity shadow follows every data write, including clear zeros
  always_ff @(posedge clk) begin
    if (clr_wr) begin
      par_mem[clr_addr] <= '0;
    end else if (wr_acc) begin
      par_mem[waddr] <= lane_par(wr_word);
    end
  end

  // Forwarded words carry fresh parity, so they never flag
  assign rd_perr = ~hit
                 & (|(lane_par(mem[raddr]) ^ par_mem[raddr]));
`else
  assign rd_perr = 1'b0;
`endif

  // Optional second read stage
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_perr <= 1'b0;
      s1_data <= '0;
    end else begin
      s1_vld  <= rd_acc;
      s1_perr <= rd_acc & rd_perr;
      if (rd_acc) s1_data <= rd_word;
    end
  end

  assign o_vld  = (READ_LATENCY == 2) ? s1_vld  : rd_acc;
  assign o_perr = (READ_LATENCY == 2) ? s1_perr : rd_perr;
  assign o_data = (READ_LATENCY == 2) ? s1_data : rd_word;

  // Output register: hold or zero the word between valid beats
  always_ff @(posedge clk) begin
    if (rst) begin
      dout     <= '0;
      dout_vld <= 1'b0;
      par_err  <= 1'b0;
    end else begin
      dout_vld <= o_vld;
      par_err  <= o_vld & o_perr;
      if (o_vld) begin
        dout <= o_data;
      end else if (STATE_KEEP == 0) begin
        dout <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dpram_sclk_be.sv
// tb_dpram_sclk_be: two instances (lat1/bypass/keep, lat2/no-bypass/zero)
// driven in lockstep, checked against a word model and queues.
module tb_dpram_sclk_be;

  localparam int AW = 9;
  localparam int DW = 16;
  localparam int NB = 2;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          p;
    logic [31:0]   c;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] raddr = '0;
  logic [AW-1:0] waddr = '0;
  logic          re = 1'b0;
  logic          we = 1'b0;
  logic [NB-1:0] wbe = '0;
  logic [DW-1:0] din = '0;

  logic [DW-1:0] dout1, dout2;
  logic          vld1, vld2;
  logic          done1, done2;
  logic          perr1, perr2;

  exp_t          q1[$];
  exp_t          q2[$];
  logic [DW-1:0] m [1<<AW];
  logic          pbad [1<<AW];
  logic [DW-1:0] last [2];
  bit            mready = 1'b0;
  int unsigned   cyc = 0;
  int            passed = 0;
  int            total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dpram_sclk_be #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
    .READ_LATENCY(1), .ENABLE_BYPASS(1),
    .CLEAR_ON_RESET(1), .STATE_KEEP(1)
  ) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .re(re),
    .waddr(waddr), .we(we), .wbe(wbe), .din(din),
    .dout(dout1), .dout_vld(vld1), .init_done(done1),
    .par_err(perr1)
  );

  dpram_sclk_be #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
    .READ_LATENCY(2), .ENABLE_BYPASS(0),
    .CLEAR_ON_RESET(1), .STATE_KEEP(0)
  ) dut2 (
    .clk(clk), .rst(rst), .raddr(raddr), .re(re),
    .waddr(waddr), .we(we), .wbe(wbe), .din(din),
    .dout(dout2), .dout_vld(vld2), .init_done(done2),
    .par_err(perr2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic mon(input int k, input logic v, input logic [DW-1:0] d,
                     input logic p, input logic dn);
    exp_t e;
    if (rst) begin
      chk($sformatf("rst_vld%0d", k), 32'(v), 32'(0));
      chk($sformatf("rst_dout%0d", k), 32'(d), 32'(0));
      chk($sformatf("rst_perr%0d", k), 32'(p), 32'(0));
      chk($sformatf("rst_init%0d", k), 32'(dn), 32'(0));
      last[k] = '0;
    end else if (v) begin
      if ((k == 0 && q1.size() == 0) || (k == 1 && q2.size() == 0)) begin
        chk($sformatf("spurious_vld%0d", k), 32'(v), 32'(0));
      end else begin
        e = (k == 0) ? q1.pop_front() : q2.pop_front();
        chk($sformatf("dout%0d", k), 32'(d), 32'(e.d));
        chk($sformatf("perr%0d", k), 32'(p), 32'(e.p));
        chk($sformatf("lat%0d", k), cyc, e.c);
        last[k] = d;
      end
    end else begin
      chk($sformatf("idle_dout%0d", k), 32'(d),
          32'((k == 0) ? last[0] : 16'h0));
      chk($sformatf("idle_perr%0d", k), 32'(p), 32'(0));
    end
  endtask

  always @(posedge clk) begin
    #1;
    mon(0, vld1, dout1, perr1, done1);
    mon(1, vld2, dout2, perr2, done2);
  end

  // One cycle of stimulus, starting just after a falling edge
  task automatic step(input bit r, input int ra, input bit w, input int wa,
                      input logic [NB-1:0] be, input logic [DW-1:0] d);
    logic [DW-1:0] mg;
    exp_t          e;
    re = r; raddr = AW'(ra);
    we = w; waddr = AW'(wa);
    wbe = be; din = d;
    if (mready) begin
      mg = m[wa];
      for (int i = 0; i < NB; i++)
        if (be[i]) mg[i*8 +: 8] = d[i*8 +: 8];
      if (r) begin
        if (w && be != 0 && ra == wa) begin
          e.d = mg; e.p = 1'b0;
        end else begin
          e.d = m[ra]; e.p = pbad[ra];
        end
        e.c = cyc + 1;
        q1.push_back(e);
        e.d = m[ra]; e.p = pbad[ra]; e.c = cyc + 2;
        q2.push_back(e);
      end
      if (w && be != 0) begin
        m[wa] = mg; pbad[wa] = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 2'b00, 16'h0);
  endtask

  task automatic do_reset(input int n);
    mready = 1'b0;
    rst = 1'b1;
    idle(n);
    rst = 1'b0;
    for (int i = 0; i < (1<<AW); i++) begin
      m[i] = '0; pbad[i] = 1'b0;
    end
  endtask

  // Sweep covers edges R+1..R+512; init_done shows after R+513
  task automatic wait_clear(input bit poke);
    for (int k = 1; k <= 512; k++)
      step(poke && k < 12, 5, poke && k >= 4 && k < 12, 3,
           2'b11, 16'hFFFF);
    chk("init_pre1", 32'(done1), 32'(0));
    chk("init_pre2", 32'(done2), 32'(0));
    idle(1);
    chk("init_rise1", 32'(done1), 32'(1));
    chk("init_rise2", 32'(done2), 32'(1));
    mready = 1'b1;
  endtask

  initial begin
    dut.mem[0]    = 16'hDEAD;  dut2.mem[0]   = 16'hDEAD;
    dut.mem[3]    = 16'hBEEF;  dut2.mem[3]   = 16'hBEEF;
    dut.mem[255]  = 16'hC0DE;  dut2.mem[255] = 16'hC0DE;
    dut.mem[511]  = 16'hF00D;  dut2.mem[511] = 16'hF00D;

    do_reset(3);
    wait_clear(1'b1);

    step(1, 0, 0, 0, 2'b00, 16'h0);
    step(1, 255, 0, 0, 2'b00, 16'h0);
    step(1, 511, 0, 0, 2'b00, 16'h0);
    step(1, 3, 0, 0, 2'b00, 16'h0);
    step(1, 5, 0, 0, 2'b00, 16'h0);
    idle(3);

    step(0, 0, 1, 5, 2'b11, 16'hABCD);
    step(0, 0, 1, 5, 2'b01, 16'h1234);
    step(1, 5, 0, 0, 2'b00, 16'h0);
    idle(3);

    step(0, 0, 1, 7, 2'b11, 16'h5555);
    step(1, 7, 1, 7, 2'b10, 16'hAAAA);
    step(1, 7, 0, 0, 2'b00, 16'h0);
    step(0, 0, 1, 7, 2'b11, 16'h1357);
    step(1, 7, 0, 0, 2'b00, 16'h0);
    step(1, 7, 1, 7, 2'b00, 16'hFFFF);
    idle(3);

    for (int i = 0; i < 16; i++)
      step(0, 0, 1, i, 2'b11, 16'h1000 + 16'(i) * 16'h0111);
    for (int i = 0; i < 16; i++)
      step(1, i, 0, 0, 2'b00, 16'h0);
    idle(4);

`ifdef DPRAM_SCLK_PARITY_EN
    step(0, 0, 1, 9, 2'b11, 16'h0F0F);
    idle(1);
    dut.mem[9]  = dut.mem[9]  ^ 16'h0008;
    dut2.mem[9] = dut2.mem[9] ^ 16'h0008;
    m[9] = m[9] ^ 16'h0008;
    pbad[9] = 1'b1;
    step(1, 9, 0, 0, 2'b00, 16'h0);
    step(1, 10, 0, 0, 2'b00, 16'h0);
    step(0, 0, 1, 9, 2'b01, 16'h00AA);
    step(1, 9, 0, 0, 2'b00, 16'h0);
    idle(3);
`endif

    do_reset(2);
    idle(200);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    wait_clear(1'b0);
    step(1, 5, 0, 0, 2'b00, 16'h0);
    step(1, 15, 0, 0, 2'b00, 16'h0);
    idle(4);

    chk("q1_drained", 32'(q1.size()), 32'(0));
    chk("q2_drained", 32'(q2.size()), 32'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
